// File: rtl/pulse_burst_pkg.sv
// Shared definitions for the pulse burst generator.
//   - burst_state_e : FSM state encoding (idle, delay, high, low)
//   - DefCntWidth   : default width of the delay / period / high-length counters
//   - DefNumWidth   : default width of the pulse-count field
// Optional build macro used by pulse_burst_gen: PULSE_BURST_GEN_RETRIGGER_EN.
package pulse_burst_pkg;

  localparam int unsigned DefCntWidth = 32;
  localparam int unsigned DefNumWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StHigh,
    StLow
  } burst_state_e;

endpackage

// File: rtl/burst_timer.sv
// Loadable down-counter shared by all timed phases of the burst generator.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset (count cleared to 0)
//   load_i     - load load_val_i into the counter (has priority over en_i)
//   load_val_i - value to load
//   en_i       - decrement by one when the count is non-zero
//   zero_o     - count is zero
module burst_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse burst generator: each accepted one-cycle trigger starts a programmable
// delay followed by a burst of num_pulses pulses of programmable high length
// and period. All outputs are registered.
// Build option: define PULSE_BURST_GEN_RETRIGGER_EN to let a trigger restart
// the block from any non-idle state; by default such triggers are dropped.
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset, aborts any burst
//   trig_pulse - one-cycle trigger
//   delay      - cycles from trigger acceptance to first rise of pulse_out
//   period     - cycles between rising edges (min high length + 1)
//   high_len   - cycles pulse_out stays high (min 1)
//   num_pulses - pulses per burst (0 gives only a done strobe)
//   pulse_out  - burst output
//   busy       - burst in progress
//   done       - one-cycle strobe at the end of each burst
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DefCntWidth,
  parameter int unsigned NUM_WIDTH = DefNumWidth
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 trig_pulse,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] high_len,
  input  logic [NUM_WIDTH-1:0] num_pulses,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done
);

  burst_state_e state_q, state_d;

  // Phase lengths are stored minus one so the timer reaches zero on the
  // edge that ends the phase.
  logic [CNT_WIDTH-1:0] hl_m1_q, hl_m1_d;
  logic [CNT_WIDTH-1:0] low_m1_q, low_m1_d;
  logic [NUM_WIDTH-1:0] rem_q, rem_d;
  // Zero-pulse trigger seen: strobe done one cycle later without leaving idle.
  logic                 zero_pend_q, zero_pend_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tmr_load;
  logic [CNT_WIDTH-1:0] tmr_val;
  logic                 tmr_en;
  logic                 tmr_zero;

  logic                 accept;
  logic [CNT_WIDTH-1:0] hl_eff;
  logic [CNT_WIDTH-1:0] hl_m1_new;
  logic [CNT_WIDTH-1:0] low_m1_new;

  // Effective lengths; the low gap is derived directly so a maximal high_len
  // never overflows the period computation.
  always_comb begin
    hl_eff     = (high_len == '0) ? CNT_WIDTH'(1) : high_len;
    hl_m1_new  = hl_eff - CNT_WIDTH'(1);
    low_m1_new = (period > hl_eff) ? (period - hl_eff - CNT_WIDTH'(1)) : '0;
  end

`ifdef PULSE_BURST_GEN_RETRIGGER_EN
  assign accept = trig_pulse && ((state_q != StIdle) || !zero_pend_q);
`else
  assign accept = trig_pulse && (state_q == StIdle) && !zero_pend_q;
`endif

  always_comb begin
    state_d     = state_q;
    hl_m1_d     = hl_m1_q;
    low_m1_d    = low_m1_q;
    rem_d       = rem_q;
    zero_pend_d = 1'b0;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;

    if (accept) begin
      hl_m1_d  = hl_m1_new;
      low_m1_d = low_m1_new;
      rem_d    = num_pulses;
      if (num_pulses == '0) begin
        state_d     = StIdle;
        zero_pend_d = 1'b1;
      end else begin
        // Delay phase lasts delay+1 cycles: the acceptance edge is not counted.
        state_d  = StDelay;
        tmr_load = 1'b1;
        tmr_val  = delay;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          done_d = zero_pend_q;
        end
        StDelay: begin
          if (tmr_zero) begin
            state_d  = StHigh;
            rem_d    = rem_q - NUM_WIDTH'(1);
            tmr_load = 1'b1;
            tmr_val  = hl_m1_q;
          end else begin
            tmr_en = 1'b1;
          end
        end
        StHigh: begin
          if (tmr_zero) begin
            if (rem_q == '0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d  = StLow;
              tmr_load = 1'b1;
              tmr_val  = low_m1_q;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        StLow: begin
          if (tmr_zero) begin
            state_d  = StHigh;
            rem_d    = rem_q - NUM_WIDTH'(1);
            tmr_load = 1'b1;
            tmr_val  = hl_m1_q;
          end else begin
            tmr_en = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    pulse_d = (state_d == StHigh);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      hl_m1_q     <= '0;
      low_m1_q    <= '0;
      rem_q       <= '0;
      zero_pend_q <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hl_m1_q     <= hl_m1_d;
      low_m1_q    <= low_m1_d;
      rem_q       <= rem_d;
      zero_pend_q <= zero_pend_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  burst_timer #(
    .Width(CNT_WIDTH)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (tmr_en),
    .zero_o    (tmr_zero)
  );

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed self-checking bench for pulse_burst_gen.
module tb_pulse_burst_gen;

  logic        clk;
  logic        resetn;
  logic        trig_pulse;
  logic [31:0] delay;
  logic [31:0] period;
  logic [31:0] high_len;
  logic [15:0] num_pulses;
  logic        pulse_out;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  pulse_burst_gen dut (
    .clk       (clk),
    .resetn    (resetn),
    .trig_pulse(trig_pulse),
    .delay     (delay),
    .period    (period),
    .high_len  (high_len),
    .num_pulses(num_pulses),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveform: k = edges after the accepting edge T (k=0 is T itself).
  function automatic int eff_hl(int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int eff_per(int p, int h);
    return (p > eff_hl(h)) ? p : eff_hl(h) + 1;
  endfunction

  function automatic logic exp_pulse(int k, int d, int p, int h, int n);
    int j;
    if (n == 0 || k < 1 + d) return 1'b0;
    j = k - 1 - d;
    if (j / eff_per(p, h) >= n) return 1'b0;
    return (j % eff_per(p, h)) < eff_hl(h);
  endfunction

  function automatic int end_edge(int d, int p, int h, int n);
    if (n == 0) return 1;
    return 1 + d + (n - 1) * eff_per(p, h) + eff_hl(h);
  endfunction

  function automatic logic exp_busy(int k, int d, int p, int h, int n);
    return (n != 0) && (k < end_edge(d, p, h, n));
  endfunction

  function automatic logic exp_done(int k, int d, int p, int h, int n);
    return k == end_edge(d, p, h, n);
  endfunction

  task automatic set_inputs(int d, int p, int h, int n);
    delay      = d;
    period     = p;
    high_len   = h;
    num_pulses = 16'(n);
  endtask

  // Drives a one-cycle trigger; returns #1 after the accepting edge.
  task automatic fire;
    @(negedge clk);
    trig_pulse = 1'b1;
    @(posedge clk);
    #1;
    trig_pulse = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    n_checks++;
    if (pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: got %b expected 0", pulse_out);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_burst(string name, int d, int p, int h, int n, int last_k);
    set_inputs(d, p, h, n);
    fire();
    for (int k = 0; k <= last_k; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (pulse_out !== exp_pulse(k, d, p, h, n)) begin
        n_fail++;
        $display("FAIL %s_pulse k=%0d: got %b expected %b", name, k, pulse_out,
                 exp_pulse(k, d, p, h, n));
      end
      n_checks++;
      if (busy !== exp_busy(k, d, p, h, n)) begin
        n_fail++;
        $display("FAIL %s_busy k=%0d: got %b expected %b", name, k, busy,
                 exp_busy(k, d, p, h, n));
      end
      n_checks++;
      if (done !== exp_done(k, d, p, h, n)) begin
        n_fail++;
        $display("FAIL %s_done k=%0d: got %b expected %b", name, k, done,
                 exp_done(k, d, p, h, n));
      end
    end
  endtask

  task automatic test_midburst;
    logic ep, eb, ed;
    set_inputs(10, 8, 3, 4);
    fire();
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 5) set_inputs(2, 5, 2, 2);
      if (k == 20) trig_pulse = 1'b1;
      @(posedge clk);
      #1;
      trig_pulse = 1'b0;
`ifdef PULSE_BURST_GEN_RETRIGGER_EN
      if (k >= 20) begin
        ep = exp_pulse(k - 20, 2, 5, 2, 2);
        eb = exp_busy(k - 20, 2, 5, 2, 2);
        ed = exp_done(k - 20, 2, 5, 2, 2);
      end else begin
        ep = exp_pulse(k, 10, 8, 3, 4);
        eb = exp_busy(k, 10, 8, 3, 4);
        ed = exp_done(k, 10, 8, 3, 4);
      end
`else
      ep = exp_pulse(k, 10, 8, 3, 4);
      eb = exp_busy(k, 10, 8, 3, 4);
      ed = exp_done(k, 10, 8, 3, 4);
`endif
      n_checks++;
      if (pulse_out !== ep) begin
        n_fail++;
        $display("FAIL mid_pulse k=%0d: got %b expected %b", k, pulse_out, ep);
      end
      n_checks++;
      if (busy !== eb) begin
        n_fail++;
        $display("FAIL mid_busy k=%0d: got %b expected %b", k, busy, eb);
      end
      n_checks++;
      if (done !== ed) begin
        n_fail++;
        $display("FAIL mid_done k=%0d: got %b expected %b", k, done, ed);
      end
    end
  endtask

  task automatic test_reset_mid;
    set_inputs(10, 8, 3, 4);
    fire();
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre_pulse: got %b expected 1", pulse_out);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_pulse: got %b expected 0", pulse_out);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_done: got %b expected 0", done);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    test_burst("after_rst", 10, 8, 3, 4, 40);
  endtask

  task automatic test_back_to_back;
    set_inputs(0, 0, 0, 1);
    fire();
    @(posedge clk);
    #1;
    n_checks++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_pulse: got %b expected 1", pulse_out);
    end
    // Trigger coincident with the done edge.
    fire();
`ifdef PULSE_BURST_GEN_RETRIGGER_EN
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_edge: got done=%b busy=%b pulse=%b expected 0 1 0",
               done, busy, pulse_out);
    end
`else
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_edge: got done=%b busy=%b pulse=%b expected 1 0 0",
               done, busy, pulse_out);
    end
`endif
    fire();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_pulse: got %b expected 1", pulse_out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_done: got done=%b busy=%b pulse=%b expected 1 0 0",
               done, busy, pulse_out);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    trig_pulse = 1'b0;
    set_inputs(0, 0, 0, 0);
    test_reset();
    test_burst("basic", 10, 8, 3, 4, 40);
    test_burst("min", 0, 0, 0, 2, 6);
    test_burst("zero", 5, 5, 5, 0, 4);
    test_burst("long_hl", 1, 2, 4, 3, 20);
    test_midburst();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
